uart_rx: RTL and testbench

//  Serial receive half of the simple UART: recovers 8N1-style frames from rx_in

---
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1-style serial receiver with holding register,
// unload strobe and empty / framing-error / overrun status.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 rxclk,
    input  logic                 reset_n,
    input  logic                 rx_in,
    input  logic                 rx_enable,
    input  logic                 uld_rx_data,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_empty,
    output logic                 rx_frame_err,
    output logic                 rx_over_run,
    output logic                 rx_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [TW-1:0]          tc;
    logic [BW-1:0]          bc;
    logic [DATA_BITS-1:0]   shift;
    logic                   rx_s;
    logic                   done;

    assign rx_s = sync[SYNC_STAGES-1];
    // Stop sample cycle; a disabled receiver never completes a frame.
    assign done = rx_enable && state == STOP && tc == LAST;

    always_ff @(posedge rxclk or negedge reset_n) begin
        if (!reset_n) begin
            sync         <= '1;
            state        <= IDLE;
            tc           <= '0;
            bc           <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_empty     <= 1'b1;
            rx_frame_err <= 1'b0;
            rx_over_run  <= 1'b0;
            rx_busy      <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_in};
            if (done && (rx_empty || uld_rx_data)) begin
                rx_data      <= shift;
                rx_empty     <= 1'b0;
                rx_frame_err <= !rx_s;
                rx_over_run  <= 1'b0;
            end else if (done) begin
                rx_over_run <= 1'b1;
            end else if (uld_rx_data && !rx_empty) begin
                rx_empty     <= 1'b1;
                rx_frame_err <= 1'b0;
                rx_over_run  <= 1'b0;
            end
            if (!rx_enable) begin
                state   <= IDLE;
                tc      <= '0;
                bc      <= '0;
                rx_busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        tc <= '0;
                        if (!rx_s) begin
                            state   <= START;
                            rx_busy <= 1'b1;
                        end
                    end
                    START: begin
                        tc <= tc == MID ? '0 : tc + 1'b1;
                        if (tc == MID) begin
                            state   <= rx_s ? IDLE : DATA;
                            rx_busy <= !rx_s;
                            bc      <= '0;
                        end
                    end
                    DATA: begin
                        tc <= tc == LAST ? '0 : tc + 1'b1;
                        if (tc == LAST) begin
                            shift[bc] <= rx_s;
                            bc        <= bc + 1'b1;
                            if (bc == BLAST) state <= STOP;
                        end
                    end
                    STOP: begin
                        tc <= tc == LAST ? '0 : tc + 1'b1;
                        if (tc == LAST) begin
                            state   <= rx_s ? IDLE : WAIT_HI;
                            rx_busy <= !rx_s;
                        end
                    end
                    WAIT_HI: begin
                        tc <= '0;
                        if (rx_s) begin
                            state   <= IDLE;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed and randomized frames against a frame-level model
// of the holding register and its status flags.
module tb_uart_rx;
    localparam int OS = 16;
    localparam int FRAME = 10 * OS;
    localparam int STOP_SAMPLE = 154;

    logic       rxclk = 0;
    logic       reset_n = 0;
    logic       rx_in = 1;
    logic       rx_enable = 1;
    logic       uld_rx_data = 0;
    logic [7:0] rx_data;
    logic       rx_empty, rx_frame_err, rx_over_run, rx_busy;

    int tests = 0;
    int fails = 0;

    logic [7:0] m_data = 0;
    logic       m_empty = 1, m_ferr = 0, m_ovr = 0;

    uart_rx dut (
        .rxclk(rxclk), .reset_n(reset_n), .rx_in(rx_in), .rx_enable(rx_enable),
        .uld_rx_data(uld_rx_data), .rx_data(rx_data), .rx_empty(rx_empty),
        .rx_frame_err(rx_frame_err), .rx_over_run(rx_over_run), .rx_busy(rx_busy)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic busy);
        chk({tag, ".data"}, 32'(rx_data), 32'(m_data));
        chk({tag, ".empty"}, 32'(rx_empty), 32'(m_empty));
        chk({tag, ".ferr"}, 32'(rx_frame_err), 32'(m_ferr));
        chk({tag, ".ovr"}, 32'(rx_over_run), 32'(m_ovr));
        chk({tag, ".busy"}, 32'(rx_busy), 32'(busy));
    endtask

    function automatic void m_complete(input logic [7:0] d, input logic stop, input logic uld);
        if (m_empty || uld) begin
            m_data = d; m_empty = 0; m_ferr = !stop; m_ovr = 0;
        end else m_ovr = 1;
    endfunction

    function automatic void m_unload();
        if (!m_empty) begin
            m_empty = 1; m_ferr = 0; m_ovr = 0;
        end
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge rxclk);
    endtask

    // Cycle c of the frame is driven at a negedge; uld_at selects one cycle for the strobe.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int uld_at);
        int busy_cnt;
        busy_cnt = 0;
        for (int c = 0; c < FRAME; c++) begin
            @(negedge rxclk);
            busy_cnt += int'(rx_busy);
            rx_in = c < OS ? 1'b0 : c < 9 * OS ? d[c / OS - 1] : stop;
            uld_rx_data = (c == uld_at);
        end
        @(negedge rxclk);
        uld_rx_data = 0;
        if (stop) chk("busy_len", 32'(busy_cnt >= 148 && busy_cnt <= 156), 1);
    endtask

    task automatic unload();
        @(negedge rxclk);
        uld_rx_data = 1;
        @(negedge rxclk);
        uld_rx_data = 0;
        m_unload();
    endtask

    initial begin
        logic [7:0] d;
        logic       st, u;
        idle(3);
        chk_all("reset", 0);
        reset_n = 1;
        idle(5);
        chk_all("post_reset", 0);

        send_frame(8'hA5, 1, -1);
        m_complete(8'hA5, 1, 0);
        chk_all("a5", 0);
        unload();
        chk_all("a5_unload", 0);

        rx_in = 0; idle(4); rx_in = 1; idle(20);
        chk_all("glitch", 0);

        send_frame(8'h3C, 0, -1);
        m_complete(8'h3C, 0, 0);
        idle(40);
        chk_all("break", 1);
        rx_in = 1; idle(6);
        chk_all("break_release", 0);
        unload();
        chk_all("break_unload", 0);
        send_frame(8'h81, 1, -1);
        m_complete(8'h81, 1, 0);
        chk_all("after_break", 0);
        unload();

        send_frame(8'h11, 1, -1);
        m_complete(8'h11, 1, 0);
        send_frame(8'h22, 1, -1);
        m_complete(8'h22, 1, 0);
        chk_all("overrun", 0);
        unload();
        chk_all("overrun_unload", 0);

        send_frame(8'h11, 1, -1);
        m_complete(8'h11, 1, 0);
        send_frame(8'h5A, 1, STOP_SAMPLE);
        m_complete(8'h5A, 1, 1);
        chk_all("uld_on_load", 0);
        unload();

        rx_in = 0; idle(OS); rx_in = 1; idle(2 * OS);
        rx_enable = 0; idle(2);
        chk("disable_busy", 32'(rx_busy), 0);
        idle(OS * 8);
        rx_enable = 1; idle(4);
        chk_all("disabled_ff", 0);
        send_frame(8'h0F, 1, -1);
        m_complete(8'h0F, 1, 0);
        chk_all("reenable_0f", 0);
        unload();

        for (int k = 0; k < 10; k++) begin
            d = 8'($urandom);
            st = ($urandom_range(0, 3) != 0);
            u = 1'($urandom);
            if (u) unload();
            send_frame(d, st, -1);
            m_complete(d, st, 0);
            rx_in = 1; idle(6);
            chk_all($sformatf("rand%0d", k), 0);
        end

        send_frame(8'hC3, 1, -1);
        rx_in = 0; idle(50);
        #2 reset_n = 0;
        #1;
        m_data = 0; m_empty = 1; m_ferr = 0; m_ovr = 0;
        chk_all("async_reset", 0);
        rx_in = 1;
        idle(3);
        reset_n = 1;
        idle(200);
        chk_all("after_reset", 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
